// File: rtl/microroc_acq_sequencer.sv
// -----------------------------------------------------------------------------
// microroc_acq_sequencer
//
// Run sequencer for a MICROROC-style front-end ASIC. A run goes through:
//   IDLE -> RST_ASIC -> PWR_UP -> ACQ -> END_HOLD -> READOUT -> DRAIN -> DONE
// In continuous mode DONE loops back to PWR_UP until a stop is requested.
//
// Ports
//   clk_i            40 MHz clock, rising edge
//   reset_n_i        asynchronous active-low reset
//   force_reset_i    synchronous abort back to IDLE
//   run_start_i      1-cycle start pulse (ignored while busy)
//   run_stop_i       1-cycle stop request (current cycle completes)
//   run_mode_i       0 = single cycle, 1 = continuous
//   ext_trig_mode_i  1 = rising edge of ext_trigger_i ends acquisition
//   ext_trigger_i    asynchronous external trigger
//   acq_time_i       acquisition length in clock cycles (0 acts as 1)
//   end_hold_time_i  wait between acquisition and readout (0 acts as 1)
//   pwr_pulsing_en_i 1 = power pulsing enabled
//   pwr_settle_i     power-up settle time in clock cycles
//   chain_mask_i     per-chain readout participation
//   chipsatb_i       ASIC memory full, active low
//   end_readout_i    per-chain readout-done level
//   fifo_empty_i     downstream FIFO empty
//   start_acq_o, reset_b_o, pwr_on_a_o, pwr_on_d_o, start_readout_o,
//   busy_o, once_end_o, cycle_count_o, ro_error_o   (all registered)
// -----------------------------------------------------------------------------
module microroc_acq_sequencer #(
  parameter int NUM_CHAIN  = 2,
  parameter int ACQ_TIME_W = 16,
  parameter int SETTLE_W   = 8,
  parameter int RO_TIMEOUT = 65535
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  force_reset_i,
  input  logic                  run_start_i,
  input  logic                  run_stop_i,
  input  logic                  run_mode_i,
  input  logic                  ext_trig_mode_i,
  input  logic                  ext_trigger_i,
  input  logic [ACQ_TIME_W-1:0] acq_time_i,
  input  logic [ACQ_TIME_W-1:0] end_hold_time_i,
  input  logic                  pwr_pulsing_en_i,
  input  logic [SETTLE_W-1:0]   pwr_settle_i,
  input  logic [NUM_CHAIN-1:0]  chain_mask_i,
  input  logic                  chipsatb_i,
  input  logic [NUM_CHAIN-1:0]  end_readout_i,
  input  logic                  fifo_empty_i,
  output logic                  start_acq_o,
  output logic                  reset_b_o,
  output logic                  pwr_on_a_o,
  output logic                  pwr_on_d_o,
  output logic [NUM_CHAIN-1:0]  start_readout_o,
  output logic                  busy_o,
  output logic                  once_end_o,
  output logic [15:0]           cycle_count_o,
  output logic                  ro_error_o
);

  // One shared phase timer serves RST_ASIC, PWR_UP, ACQ and END_HOLD, so it
  // must be wide enough for both the acquisition and the settle values.
  localparam int TMR_W0   = (ACQ_TIME_W > SETTLE_W) ? ACQ_TIME_W : SETTLE_W;
  localparam int TMR_W    = (TMR_W0 < 2) ? 2 : TMR_W0;
  localparam int RO_CNT_W = $clog2(RO_TIMEOUT + 1);
  localparam int IDX_W    = (NUM_CHAIN > 1) ? $clog2(NUM_CHAIN) : 1;

  typedef enum logic [2:0] {
    IDLE, RST_ASIC, PWR_UP, ACQ, END_HOLD, READOUT, DRAIN, DONE
  } state_e;

  state_e               state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d, tmr_next;
  logic                 stop_q, stop_d;
  logic [NUM_CHAIN-1:0] pending_q, pending_d;
  logic                 waiting_q, waiting_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [RO_CNT_W-1:0]  ro_tmr_q, ro_tmr_d;
  logic                 ro_error_q, ro_error_d;
  logic [15:0]          cycle_count_q, cycle_count_d;
  logic [NUM_CHAIN-1:0] start_readout_d;
  logic                 pwr_a_d, pwr_d_d;
  logic                 ext_meta_q, ext_sync_q, ext_prev_q, ext_rise;
  logic                 found;
  logic [IDX_W-1:0]     sel;

  // Two-flop synchroniser for the asynchronous trigger, plus a delayed copy
  // for rising-edge detection.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ext_meta_q <= 1'b0;
      ext_sync_q <= 1'b0;
      ext_prev_q <= 1'b0;
    end else begin
      ext_meta_q <= ext_trigger_i;
      ext_sync_q <= ext_meta_q;
      ext_prev_q <= ext_sync_q;
    end
  end

  assign ext_rise = ext_sync_q & ~ext_prev_q;
  assign tmr_next = tmr_q + TMR_W'(1);

  // Next-state logic. Phase durations compare tmr_next against the
  // programmed length so that a length of 0 behaves as a single cycle.
  always_comb begin
    state_d         = state_q;
    tmr_d           = tmr_q;
    stop_d          = stop_q | ((state_q != IDLE) & run_stop_i);
    pending_d       = pending_q;
    waiting_d       = waiting_q;
    cur_d           = cur_q;
    ro_tmr_d        = ro_tmr_q;
    ro_error_d      = ro_error_q;
    cycle_count_d   = cycle_count_q;
    start_readout_d = '0;
    found           = 1'b0;
    sel             = '0;

    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (run_start_i) begin
          state_d       = RST_ASIC;
          tmr_d         = '0;
          ro_error_d    = 1'b0;
          cycle_count_d = '0;
        end
      end
      RST_ASIC: begin
        if (tmr_q == TMR_W'(3)) begin
          state_d = PWR_UP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_next;
        end
      end
      PWR_UP: begin
        if (!pwr_pulsing_en_i || (tmr_next >= TMR_W'(pwr_settle_i))) begin
          state_d = ACQ;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_next;
        end
      end
      ACQ: begin
        if ((tmr_next >= TMR_W'(acq_time_i)) || !chipsatb_i ||
            (ext_trig_mode_i && ext_rise)) begin
          state_d = END_HOLD;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_next;
        end
      end
      END_HOLD: begin
        if (tmr_next >= TMR_W'(end_hold_time_i)) begin
          state_d   = READOUT;
          tmr_d     = '0;
          pending_d = chain_mask_i;
          waiting_d = 1'b0;
          ro_tmr_d  = '0;
        end else begin
          tmr_d = tmr_next;
        end
      end
      READOUT: begin
        // While waiting, ro_tmr_q == 0 marks the pulse cycle itself; the
        // done level is only trusted from the following cycle onward.
        if (waiting_q) begin
          if (ro_tmr_q == '0) begin
            ro_tmr_d = RO_CNT_W'(1);
          end else if (end_readout_i[cur_q]) begin
            waiting_d = 1'b0;
          end else if (ro_tmr_q == RO_CNT_W'(RO_TIMEOUT)) begin
            ro_error_d = 1'b1;
            waiting_d  = 1'b0;
          end else begin
            ro_tmr_d = ro_tmr_q + RO_CNT_W'(1);
          end
        end else if (pending_q == '0) begin
          state_d = DRAIN;
        end else begin
          for (int i = 0; i < NUM_CHAIN; i++) begin
            if (pending_q[i] && !found) begin
              found = 1'b1;
              sel   = IDX_W'(i);
            end
          end
          cur_d                = sel;
          pending_d[sel]       = 1'b0;
          waiting_d            = 1'b1;
          ro_tmr_d             = '0;
          start_readout_d[sel] = 1'b1;
        end
      end
      DRAIN: begin
        if (fifo_empty_i) begin
          state_d       = DONE;
          cycle_count_d = cycle_count_q + 16'd1;
        end
      end
      DONE: begin
        tmr_d = '0;
        if (run_mode_i && !stop_d) state_d = PWR_UP;
        else                       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort keeps the run statistics but drops everything else.
    if (force_reset_i) begin
      state_d         = IDLE;
      tmr_d           = '0;
      stop_d          = 1'b0;
      pending_d       = '0;
      waiting_d       = 1'b0;
      ro_tmr_d        = '0;
      ro_error_d      = ro_error_q;
      cycle_count_d   = cycle_count_q;
      start_readout_d = '0;
    end
  end

  // Power enables are decoded from the upcoming state so they stay aligned
  // with the other registered outputs.
  always_comb begin
    pwr_a_d = 1'b0;
    pwr_d_d = 1'b0;
    if (!force_reset_i) begin
      if (pwr_pulsing_en_i) begin
        pwr_a_d = (state_d == PWR_UP) || (state_d == ACQ) || (state_d == END_HOLD);
        pwr_d_d = (state_d == PWR_UP) || (state_d == ACQ) || (state_d == END_HOLD) ||
                  (state_d == READOUT) || (state_d == DRAIN);
      end else begin
        pwr_a_d = 1'b1;
        pwr_d_d = 1'b1;
      end
    end
  end

  // State, timers and all outputs are registered together.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q         <= IDLE;
      tmr_q           <= '0;
      stop_q          <= 1'b0;
      pending_q       <= '0;
      waiting_q       <= 1'b0;
      cur_q           <= '0;
      ro_tmr_q        <= '0;
      ro_error_q      <= 1'b0;
      cycle_count_q   <= '0;
      start_acq_o     <= 1'b0;
      reset_b_o       <= 1'b1;
      pwr_on_a_o      <= 1'b0;
      pwr_on_d_o      <= 1'b0;
      start_readout_o <= '0;
      busy_o          <= 1'b0;
      once_end_o      <= 1'b0;
    end else begin
      state_q         <= state_d;
      tmr_q           <= tmr_d;
      stop_q          <= stop_d;
      pending_q       <= pending_d;
      waiting_q       <= waiting_d;
      cur_q           <= cur_d;
      ro_tmr_q        <= ro_tmr_d;
      ro_error_q      <= ro_error_d;
      cycle_count_q   <= cycle_count_d;
      start_acq_o     <= (state_d == ACQ);
      reset_b_o       <= (state_d != RST_ASIC);
      pwr_on_a_o      <= pwr_a_d;
      pwr_on_d_o      <= pwr_d_d;
      start_readout_o <= start_readout_d;
      busy_o          <= (state_d != IDLE);
      once_end_o      <= (state_d == DONE);
    end
  end

  assign cycle_count_o = cycle_count_q;
  assign ro_error_o    = ro_error_q;

endmodule

// File: doc/microroc_acq_sequencer.md
MICROROC_ACQ_SEQUENCER -- requirements
Module: microroc_acq_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CHAIN, default 2: number of independent readout chains.
REQ-002 The block SHALL have parameter ACQ_TIME_W, default 16: width of the acquisition and end-hold timers.
REQ-003 The block SHALL have parameter SETTLE_W, default 8: width of the power-settle timer.
REQ-004 The block SHALL have parameter RO_TIMEOUT, default 65535: maximum Clk cycles to wait for each chain's end_readout.
REQ-005 Clk input 1: the single clock (40 MHz); all logic is clocked on its rising edge.
REQ-006 reset_n input 1: asynchronous, active-low reset.
REQ-007 force_reset input 1: synchronous abort.
REQ-008 run_start input 1: 1-cycle start pulse.
REQ-009 run_stop input 1: 1-cycle stop request.
REQ-010 run_mode input 1: 0 = single cycle, 1 = continuous.
REQ-011 ext_trig_mode input 1: 1 = an ext_trigger rising edge ends acquisition.
REQ-012 ext_trigger input 1: asynchronous to Clk, so it is double-synchronised.
REQ-013 acq_time input ACQ_TIME_W: acquisition length in Clk cycles.
REQ-014 end_hold_time input ACQ_TIME_W: wait between acquisition and readout, in Clk cycles.
REQ-015 pwr_pulsing_en input 1: 1 = power pulsing enabled.
REQ-016 pwr_settle input SETTLE_W: power-up settle time in Clk cycles.
REQ-017 chain_mask input NUM_CHAIN: 1 = chain participates in readout.
REQ-018 chipsatb input 1: ASIC memory full, active low.
REQ-019 end_readout input NUM_CHAIN: per-chain readout-done level.
REQ-020 fifo_empty input 1: downstream USB FIFO is empty.
REQ-021 start_acq output 1: ASIC acquisition enable.
REQ-022 reset_b output 1: ASIC reset, active low.
REQ-023 pwr_on_a and pwr_on_d outputs 1 each: analog and digital power enables.
REQ-024 start_readout output NUM_CHAIN: per-chain readout start pulse.
REQ-025 busy output 1; once_end output 1 (1-cycle end-of-cycle pulse); cycle_count output 16; ro_error output 1 (sticky readout timeout).

Function
REQ-026 The FSM states SHALL be IDLE, RST_ASIC, PWR_UP, ACQ, END_HOLD, READOUT, DRAIN, DONE.
REQ-027 IDLE: on run_start -> RST_ASIC; ro_error and cycle_count clear; busy=1 in all states except IDLE.
REQ-028 RST_ASIC: reset_b=0 for exactly 4 cycles, then -> PWR_UP.
REQ-029 PWR_UP: pwr_pulsing_en=1 -> wait pwr_settle cycles (0 = no wait, direct transition) then -> ACQ; pwr_pulsing_en=0 -> ACQ on next cycle.
REQ-030 ACQ: start_acq=1 from first ACQ cycle; exit -> END_HOLD on the first of: (a) acq_time cycles elapsed (acq_time=0 treated as 1), (b) chipsatb sampled 0, (c) ext_trig_mode=1 and synchronised ext_trigger rising edge; simultaneous conditions -> single transition.
REQ-031 END_HOLD: start_acq=0; wait end_hold_time cycles (0 = one cycle) -> READOUT.
REQ-032 READOUT: service set bits of chain_mask in ascending index; chain_mask sampled once on READOUT entry.
REQ-033 Per chain i: start_readout[i] 1-cycle pulse, then wait for end_readout[i]=1, sampled starting the cycle after the pulse.
REQ-034 Readout timeout: if end_readout[i] is not seen within RO_TIMEOUT cycles, ro_error is set (sticky) and the next chain is serviced.
REQ-035 chain_mask=0 -> READOUT exits to DRAIN in one cycle.
REQ-036 DRAIN: wait fifo_empty=1 -> DONE.
REQ-037 DONE lasts 1 cycle: once_end=1; cycle_count increments, wrapping 0xFFFF->0.
REQ-038 From DONE: run_mode=1 and no stop pending -> PWR_UP; otherwise -> IDLE.
REQ-039 run_stop received in any non-IDLE state SHALL latch stop pending; the current cycle completes through DONE; stop pending clears in IDLE.
REQ-040 run_start while busy SHALL be ignored.
REQ-041 Power, pwr_pulsing_en=1: pwr_on_a=1 in PWR_UP, ACQ, END_HOLD only; pwr_on_d=1 in PWR_UP through DRAIN; both 0 elsewhere.
REQ-042 Power, pwr_pulsing_en=0: pwr_on_a and pwr_on_d =1 in every state except reset.
REQ-043 force_reset=1 SHALL return the FSM to IDLE on the next edge with all outputs at reset values except cycle_count and ro_error, which hold; timers clear.
REQ-044 All outputs SHALL be registered.

Reset
REQ-045 reset_n=0 SHALL asynchronously force: state IDLE, start_acq=0, reset_b=1, pwr_on_a=0, pwr_on_d=0, start_readout=0, busy=0, once_end=0, cycle_count=0, ro_error=0, stop pending=0, all timers 0.
REQ-046 Deassertion of reset_n SHALL take effect on the next Clk edge; the first run_start is accepted one cycle after reset release.

Verification
REQ-047 Single run: acq_time=100, end_hold_time=10, pwr_pulsing_en=0, chain_mask=2'b11, each end_readout asserted 20 cycles after its start pulse -> start_acq high exactly 100 cycles; start_readout[0] then start_readout[1]; once_end once; cycle_count=1; busy low afterwards.
REQ-048 Early stop: acq_time=1000, chipsatb driven low at ACQ cycle 50 -> start_acq deasserts after 50±1 cycles.
REQ-049 External trigger: ext_trig_mode=1, acq_time=1000, ext_trigger pulsed at cycle 30 -> acquisition ends 3±1 cycles later.
REQ-050 Timeout: RO_TIMEOUT=64, chain_mask=2'b01, end_readout never asserted -> ro_error=1 after 64 cycles; DRAIN and DONE still reached.
REQ-051 Continuous with stop: run_mode=1, pwr_pulsing_en=1, pwr_settle=8, run_stop during 3rd ACQ -> cycle_count=3, IDLE; pwr_on_a low during every READOUT.
REQ-052 Aborts: force_reset mid-READOUT -> IDLE next cycle, start_readout=0; reset_n pulsed mid-ACQ -> all REQ-045 values immediately.
